// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: valid/ready operand and result channels of the shifter
interface pipelined_barrel_shifter_if #(parameter int WIDTH = 8);
  localparam int SHW = $clog2(WIDTH);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0] in_amt;
  logic [1:0] in_mode;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic out_zero;
  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input in_ready, out_valid, out_data, out_zero
  );
  modport slave (
    input in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(WIDTH)-stage SRL/SLL/SRA/ROR unit with global-stall valid/ready
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  logic en;
  assign en = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  for (genvar k = 0; k < SHW; k++) begin : g_st
    localparam int AW = SHW - k;
    localparam int SH = 1 << (AW - 1);
    logic vi, sg, vr;
    logic [AW-1:0] am;
    logic [1:0] md;
    logic [WIDTH-1:0] x, y, r;
    if (k == 0) begin : g_src
      assign vi = bus.in_valid;
      assign x = bus.in_data;
      assign am = bus.in_amt;
      assign md = bus.in_mode;
      assign sg = bus.in_data[WIDTH-1];
    end else begin : g_src
      assign vi = g_st[k-1].vr;
      assign x = g_st[k-1].r;
      assign am = g_st[k-1].g_side.ar;
      assign md = g_st[k-1].g_side.mr;
      assign sg = g_st[k-1].g_side.sr;
    end
    // the MSB of the remaining amount selects this stage's shift; consumed bits are dropped
    assign y = !am[AW-1] ? x :
               md == 2'd0 ? x >> SH :
               md == 2'd1 ? x << SH :
               md == 2'd2 ? (sg ? ~(~x >> SH) : x >> SH) :
               (x >> SH) | (x << (WIDTH - SH));
    always_ff @(posedge clk) begin
      if (rst) begin
        vr <= 1'b0;
        r <= '0;
      end else if (en) begin
        vr <= vi;
        r <= y;
      end
    end
    if (k < SHW - 1) begin : g_side
      logic [AW-2:0] ar;
      logic [1:0] mr;
      logic sr;
      always_ff @(posedge clk) begin
        if (rst) begin
          ar <= '0;
          mr <= '0;
          sr <= 1'b0;
        end else if (en) begin
          ar <= am[AW-2:0];
          mr <= md;
          sr <= sg;
        end
      end
    end
  end
  assign bus.out_valid = g_st[SHW-1].vr;
  assign bus.out_data = g_st[SHW-1].r;
  // gated by valid so a flushed pipe reports out_zero=0
  assign bus.out_zero = bus.out_valid && ~|bus.out_data;
endmodule
